// File: rtl/ifu_pkg.sv
// ifu_pkg: shared fetch-stage states and constants
package ifu_pkg;
  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_HALT = 3'd3,
    S_ERR  = 3'd4
  } state_e;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
endpackage

// File: rtl/ifu_word_sel.sv
// ifu_word_sel: pick the 32-bit word of a doubleword addressed by bit 2
module ifu_word_sel (
  input  logic        sel_i,
  input  logic [63:0] data_i,
  output logic [31:0] word_o
);
  assign word_o = sel_i ? data_i[63:32] : data_i[31:0];
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC owner, imem request/response sequencing and decode handshake
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [63:0]      imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [63:0]      imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      pc,
  output logic [31:0]      inst,
  input  logic [31:0]      dnpc,
  input  logic             halt,
  output logic             fetch_err,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);
  state_e           state_q;
  logic [31:0]      pc_q, inst_q, word;
  logic             err_q, halted_q, hs;
  logic [CNT_W-1:0] cnt_q;
  ifu_word_sel u_sel (.sel_i(pc_q[2]), .data_i(imem_rsp_data), .word_o(word));
  assign hs             = (state_q == S_HOLD) & inst_ready;
  assign imem_req_valid = ~rst & (state_q == S_REQ) & (pc_q[1:0] == 2'b00);
  assign imem_addr      = {32'b0, pc_q[31:3], 3'b000};
  assign inst_valid     = state_q == S_HOLD;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign fetch_err      = err_q;
  assign halted         = halted_q;
  assign fetch_cnt      = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      inst_q   <= NOP_INST;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_REQ:
          if (pc_q[1:0] != 2'b00) begin
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else if (imem_req_ready) state_q <= S_WAIT;
        S_WAIT:
          if (imem_rsp_valid) begin
            inst_q  <= word;
            state_q <= S_HOLD;
          end
        S_HOLD:
          if (inst_ready) begin
            if (halt) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              pc_q    <= dnpc;
              state_q <= S_REQ;
            end
          end
        default: state_q <= state_q;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (hs) cnt_q <= cnt_q + CNT_W'(1);
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed self-checking bench for ifu_fetch
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [63:0] imem_rsp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] pc, inst;
  logic [31:0] dnpc = '0;
  logic        halt = 1'b0;
  logic        fetch_err, halted;
  logic [63:0] fetch_cnt;
  int checks = 0, errors = 0;

  ifu_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .pc(pc), .inst(inst),
    .dnpc(dnpc), .halt(halt), .fetch_err(fetch_err), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic respond(input logic [63:0] d);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
  endtask

  task automatic handshake(input logic [31:0] np, input logic h);
    inst_ready = 1'b1;
    dnpc       = np;
    halt       = h;
    @(negedge clk);
    inst_ready = 1'b0;
    halt       = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 64'h8000_0000);
    chk("rst_inst", inst, 64'h13);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", fetch_cnt, 0);
    // 1) first fetch, lower word
    rst = 1'b0;
    #1;
    chk("t1_req_valid", imem_req_valid, 1);
    chk("t1_addr", imem_addr, 64'h8000_0000);
    @(negedge clk);
    chk("t1_wait_req", imem_req_valid, 0);
    chk("t1_wait_iv", inst_valid, 0);
    respond(64'h0010_0093_0000_0513);
    chk("t1_iv", inst_valid, 1);
    chk("t1_inst", inst, 64'h0000_0513);
    chk("t1_pc", pc, 64'h8000_0000);
    // 2) handshake to +4, upper word, same-cycle response ignored
    handshake(32'h8000_0004, 1'b0);
    chk("t2_cnt", fetch_cnt, 1);
    chk("t2_req_valid", imem_req_valid, 1);
    chk("t2_addr", imem_addr, 64'h8000_0000);
    chk("t2_pc", pc, 64'h8000_0004);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 64'hBAD0_BAD0_BAD1_BAD1;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("t2_early_rsp_iv", inst_valid, 0);
    @(negedge clk);
    chk("t2_wait_iv", inst_valid, 0);
    respond(64'h0010_0093_0000_0513);
    chk("t2_iv", inst_valid, 1);
    chk("t2_inst", inst, 64'h0010_0093);
    // 3) back-pressure with dnpc toggling
    for (int i = 0; i < 5; i++) begin
      dnpc = i[0] ? 32'h1234_5678 : 32'h0000_0010;
      @(negedge clk);
      chk("t3_pc", pc, 64'h8000_0004);
      chk("t3_inst", inst, 64'h0010_0093);
      chk("t3_cnt", fetch_cnt, 1);
      chk("t3_req", imem_req_valid, 0);
      chk("t3_iv", inst_valid, 1);
    end
    // 4) halt, then memory keeps poking
    handshake(32'h8000_0008, 1'b1);
    chk("t4_halted", halted, 1);
    chk("t4_cnt", fetch_cnt, 2);
    chk("t4_iv", inst_valid, 0);
    for (int i = 0; i < 4; i++) begin
      imem_rsp_valid = i[0];
      imem_rsp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      chk("t4_req", imem_req_valid, 0);
      chk("t4_iv_hold", inst_valid, 0);
      chk("t4_cnt_hold", fetch_cnt, 2);
    end
    imem_rsp_valid = 1'b0;
    // 6) reset during S_WAIT, stale response afterwards
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_req0", imem_req_valid, 1);
    @(negedge clk);
    chk("t6_in_wait", imem_req_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("t6_halted_clr", halted, 0);
    chk("t6_cnt_clr", fetch_cnt, 0);
    chk("t6_err_clr", fetch_err, 0);
    chk("t6_req", imem_req_valid, 1);
    chk("t6_addr", imem_addr, 64'h8000_0000);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("t6_stale_iv", inst_valid, 0);
    chk("t6_stale_inst", inst, 64'h13);
    respond(64'h0000_0000_1234_5678);
    chk("t6_iv", inst_valid, 1);
    chk("t6_inst", inst, 64'h1234_5678);
    // 5) misaligned next PC
    handshake(32'h8000_0102, 1'b0);
    chk("t5_cnt", fetch_cnt, 1);
    chk("t5_req", imem_req_valid, 0);
    chk("t5_pc", pc, 64'h8000_0102);
    @(negedge clk);
    chk("t5_err", fetch_err, 1);
    chk("t5_iv", inst_valid, 0);
    for (int i = 0; i < 3; i++) begin
      respond(64'h0000_0000_0000_0001);
      chk("t5_req_hold", imem_req_valid, 0);
      chk("t5_iv_hold", inst_valid, 0);
      chk("t5_err_hold", fetch_err, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
